vt100_report_tx: RTL and testbench

Terminal-to-host report generator for the virtual console. It accepts report requests from the command dispatch side (device status, cursor position, device attributes) and serialises the matching VT100 escape sequence as a byte stream toward the host-side transmitter (UART TX). It is the outbound counterpart of the inbound command parser: that path consumes host bytes, and this block produces the terminal's answers to DSR/DA queries.

---
 rtl/vt100_report_tx_pkg.sv | 48 ++++
 rtl/vt100_bin_to_bcd.sv | 25 ++
 rtl/vt100_report_tx.sv | 129 ++++++++++++
 tb/tb_vt100_report_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vt100_report_tx_pkg.sv
// rtl/vt100_report_tx_pkg.sv - shared types and ASCII constants for the VT100 report generator
package vt100_report_tx_pkg;

    typedef enum logic [1:0] {
        RPT_STATUS = 2'd0,
        RPT_CPR    = 2'd1,
        RPT_DA     = 2'd2,
        RPT_RSVD   = 2'd3
    } ReportType_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } Cursor_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ESC,
        ST_CSI,
        ST_PARAM,
        ST_FINAL
    } ReportState_t;

    localparam logic [7:0] ESC         = 8'h1B;
    localparam logic [7:0] CSI_BRACKET = 8'h5B;
    localparam logic [7:0] SEMI        = 8'h3B;
    localparam logic [7:0] QMARK       = 8'h3F;
    localparam logic [7:0] CHAR_R      = 8'h52;
    localparam logic [7:0] CHAR_n      = 8'h6E;
    localparam logic [7:0] CHAR_c      = 8'h63;
    localparam logic [7:0] CHAR_0      = 8'h30;
    localparam logic [7:0] CHAR_1      = 8'h31;

    // pos counts from the first printed digit; leading zeros are skipped via numDigits
    function automatic logic [7:0] digitChar(input logic [11:0] bcd, input logic [1:0] numDigits,
                                             input logic [2:0] pos);
        logic [2:0] sel;
        logic [3:0] d;
        sel = 3'd3 - {1'b0, numDigits} + pos;
        case (sel)
            3'd0:    d = bcd[11:8];
            3'd1:    d = bcd[7:4];
            default: d = bcd[3:0];
        endcase
        return CHAR_0 + {4'h0, d};
    endfunction

endpackage

// File: rtl/vt100_bin_to_bcd.sv
// rtl/vt100_bin_to_bcd.sv - combinational 9-bit binary to 3 BCD digits plus printed digit count
module vt100_bin_to_bcd (
    input  logic [8:0]  bin,
    output logic [11:0] bcd,
    output logic [1:0]  numDigits
);

    logic [20:0] sr;

    // shift-add-3 conversion
    always_comb begin
        sr = {12'd0, bin};
        for (int i = 0; i < 9; i++) begin
            if (sr[12:9] >= 4'd5)  sr[12:9]  = sr[12:9] + 4'd3;
            if (sr[16:13] >= 4'd5) sr[16:13] = sr[16:13] + 4'd3;
            if (sr[20:17] >= 4'd5) sr[20:17] = sr[20:17] + 4'd3;
            sr = sr << 1;
        end
        bcd = sr[20:9];
        if (bcd[11:8] != 4'd0)     numDigits = 2'd3;
        else if (bcd[7:4] != 4'd0) numDigits = 2'd2;
        else                       numDigits = 2'd1;
    end

endmodule

// File: rtl/vt100_report_tx.sv
// rtl/vt100_report_tx.sv - serialises DSR/CPR/DA answers as VT100 escape sequences
module vt100_report_tx
    import vt100_report_tx_pkg::*;
#(
    parameter int CPR_OFFSET = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqValid,
    input  ReportType_t reqType,
    output logic        reqReady,
    input  Cursor_t     cursor,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        busy
);

    localparam logic [8:0] OFFSET9 = 9'(CPR_OFFSET);

    ReportState_t state, stateNext;
    ReportType_t  typeQ;
    logic [11:0]  rowBcd, colBcd, rowBcdQ, colBcdQ;
    logic [1:0]   rowCnt, colCnt, rowCntQ, colCntQ;
    logic [2:0]   paramIdx, idxNext, paramLen;
    logic [7:0]   paramByte, finalByte;
    logic         reqReadyQ, accept, txFire;
    logic [8:0]   rowBin, colBin;

    assign rowBin   = {1'b0, cursor.y} + OFFSET9;
    assign colBin   = {1'b0, cursor.x} + OFFSET9;
    assign accept   = reqValid && reqReadyQ;
    assign txValid  = (state != ST_IDLE);
    assign txFire   = txValid && txReady;
    assign reqReady = reqReadyQ;
    assign busy     = (state != ST_IDLE);

    vt100_bin_to_bcd u_row_bcd (.bin(rowBin), .bcd(rowBcd), .numDigits(rowCnt));
    vt100_bin_to_bcd u_col_bcd (.bin(colBin), .bcd(colBcd), .numDigits(colCnt));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            paramIdx  <= 3'd0;
            reqReadyQ <= 1'b1;
            typeQ     <= RPT_STATUS;
            rowBcdQ   <= 12'd0;
            colBcdQ   <= 12'd0;
            rowCntQ   <= 2'd1;
            colCntQ   <= 2'd1;
        end else begin
            state     <= stateNext;
            paramIdx  <= idxNext;
            reqReadyQ <= (stateNext == ST_IDLE);
            if (accept) begin
                typeQ   <= reqType;
                rowBcdQ <= rowBcd;
                colBcdQ <= colBcd;
                rowCntQ <= rowCnt;
                colCntQ <= colCnt;
            end
        end
    end

    // CPR parameter layout: row digits, ';', col digits
    always_comb begin
        paramLen  = 3'd1;
        paramByte = CHAR_0;
        finalByte = CHAR_n;
        case (typeQ)
            RPT_CPR: begin
                paramLen  = {1'b0, rowCntQ} + 3'd1 + {1'b0, colCntQ};
                finalByte = CHAR_R;
                if (paramIdx < {1'b0, rowCntQ})
                    paramByte = digitChar(rowBcdQ, rowCntQ, paramIdx);
                else if (paramIdx == {1'b0, rowCntQ})
                    paramByte = SEMI;
                else
                    paramByte = digitChar(colBcdQ, colCntQ, paramIdx - {1'b0, rowCntQ} - 3'd1);
            end
            RPT_DA: begin
                paramLen  = 3'd4;
                finalByte = CHAR_c;
                case (paramIdx)
                    3'd0:    paramByte = QMARK;
                    3'd1:    paramByte = CHAR_1;
                    3'd2:    paramByte = SEMI;
                    default: paramByte = CHAR_0;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        stateNext = state;
        idxNext   = paramIdx;
        txData    = 8'h00;
        case (state)
            ST_IDLE: begin
                if (accept && reqType != RPT_RSVD) stateNext = ST_ESC;
            end
            ST_ESC: begin
                txData = ESC;
                if (txFire) stateNext = ST_CSI;
            end
            ST_CSI: begin
                txData = CSI_BRACKET;
                if (txFire) begin
                    stateNext = ST_PARAM;
                    idxNext   = 3'd0;
                end
            end
            ST_PARAM: begin
                txData = paramByte;
                if (txFire) begin
                    if (paramIdx == paramLen - 3'd1) stateNext = ST_FINAL;
                    else                             idxNext   = paramIdx + 3'd1;
                end
            end
            ST_FINAL: begin
                txData = finalByte;
                if (txFire) stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_vt100_report_tx.sv
// tb/tb_vt100_report_tx.sv - self-checking bench for vt100_report_tx
module tb_vt100_report_tx;
    import vt100_report_tx_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    ReportType_t reqType;
    logic        reqReady;
    Cursor_t     cursor;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic        busy;

    int total = 0;
    int bad = 0;
    logic [7:0] expQ[$];

    vt100_report_tx #(.CPR_OFFSET(1)) dut (
        .clk(clk), .rst(rst), .reqValid(reqValid), .reqType(reqType), .reqReady(reqReady),
        .cursor(cursor), .txData(txData), .txValid(txValid), .txReady(txReady), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void build_exp(input ReportType_t t, input logic [7:0] x, input logic [7:0] y);
        string s;
        expQ.delete();
        case (t)
            RPT_STATUS: s = $sformatf("%c[0n", 8'h1b);
            RPT_CPR:    s = $sformatf("%c[%0d;%0dR", 8'h1b, int'(y) + 1, int'(x) + 1);
            RPT_DA:     s = $sformatf("%c[?1;0c", 8'h1b);
            default:    s = "";
        endcase
        for (int i = 0; i < s.len(); i++) expQ.push_back(s[i]);
    endfunction

    task automatic run_report(input ReportType_t t, input logic [7:0] x, input logic [7:0] y,
                              input bit randStall, input bit holdReq, input string name);
        int idx;
        int cyc;
        bit prevStall;
        logic [7:0] prevData;
        build_exp(t, x, y);
        total++;
        if (reqReady !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_before: got %b want 1", name, reqReady);
        end
        reqValid = 1'b1;
        reqType  = t;
        cursor.x = x;
        cursor.y = y;
        @(posedge clk); #1;
        if (!holdReq) begin
            reqValid = 1'b0;
            reqType  = ReportType_t'($urandom_range(0, 3));
        end
        cursor.x = 8'($urandom);
        cursor.y = 8'($urandom);
        idx = 0;
        cyc = 0;
        prevStall = 1'b0;
        prevData = 8'h00;
        while (idx < expQ.size() && cyc < 300) begin
            txReady = randStall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (prevStall) begin
                total++;
                if (txValid !== 1'b1 || txData !== prevData) begin
                    bad++;
                    $display("FAIL %s stall_hold: got v=%b d=%h want v=1 d=%h", name, txValid, txData, prevData);
                end
            end
            if (!randStall) begin
                total++;
                if (txValid !== 1'b1) begin
                    bad++;
                    $display("FAIL %s no_bubble byte %0d: got txValid=%b want 1", name, idx, txValid);
                end
            end
            if (holdReq) begin
                total++;
                if (reqReady !== 1'b0) begin
                    bad++;
                    $display("FAIL %s ready_while_busy: got %b want 0", name, reqReady);
                end
            end
            if (txValid === 1'b1 && txReady) begin
                total++;
                if (txData !== expQ[idx]) begin
                    bad++;
                    $display("FAIL %s byte %0d: got %h want %h", name, idx, txData, expQ[idx]);
                end
                idx++;
                prevStall = 1'b0;
            end else begin
                prevStall = (txValid === 1'b1);
            end
            prevData = txData;
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (idx != expQ.size()) begin
            bad++;
            $display("FAIL %s timeout: got %0d bytes want %0d", name, idx, expQ.size());
        end
        total++;
        if (txValid !== 1'b0 || reqReady !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s end_state: got v=%b rdy=%b busy=%b want 0 1 0", name, txValid, reqReady, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        reqValid = 1'b0;
        reqType = RPT_STATUS;
        cursor = '0;
        txReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (txValid !== 1'b0 || txData !== 8'h00 || reqReady !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset: got v=%b d=%h rdy=%b busy=%b want 0 00 1 0", txValid, txData, reqReady, busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_status();
        run_report(RPT_STATUS, 8'd0, 8'd0, 1'b0, 1'b0, "status");
    endtask

    task automatic test_cpr_fixed();
        run_report(RPT_CPR, 8'd0, 8'd0, 1'b0, 1'b0, "cpr_0_0");
        run_report(RPT_CPR, 8'd79, 8'd23, 1'b0, 1'b0, "cpr_79_23");
        run_report(RPT_CPR, 8'd255, 8'd9, 1'b0, 1'b0, "cpr_255_9");
        run_report(RPT_CPR, 8'd98, 8'd99, 1'b0, 1'b0, "cpr_98_99");
    endtask

    task automatic test_da_stall();
        run_report(RPT_DA, 8'd0, 8'd0, 1'b1, 1'b1, "da_stall_held");
        run_report(RPT_DA, 8'd0, 8'd0, 1'b1, 1'b0, "da_next_accept");
    endtask

    task automatic test_reserved();
        run_report(RPT_RSVD, 8'd5, 8'd5, 1'b0, 1'b0, "reserved");
        repeat (3) begin
            @(negedge clk);
            total++;
            if (txValid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reserved_idle: got v=%b busy=%b want 0 0", txValid, busy);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        build_exp(RPT_CPR, 8'd41, 8'd120);
        reqValid = 1'b1;
        reqType = RPT_CPR;
        cursor.x = 8'd41;
        cursor.y = 8'd120;
        txReady = 1'b1;
        @(posedge clk); #1;
        reqValid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++;
        if (txValid !== 1'b1 || txData !== expQ[2]) begin
            bad++;
            $display("FAIL reset_mid third_byte: got v=%b d=%h want 1 %h", txValid, txData, expQ[2]);
        end
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            total++;
            if (txValid !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid drop: got txValid=%b want 0", txValid);
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (reqReady !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid release: got rdy=%b busy=%b want 1 0", reqReady, busy);
        end
        repeat (10) begin
            @(negedge clk);
            total++;
            if (txValid !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid no_resume: got txValid=%b want 0", txValid);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            run_report(ReportType_t'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                       1'($urandom_range(0, 1)), 1'b0, $sformatf("random%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_status();
        test_cpr_fixed();
        test_da_stall();
        test_reserved();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
